// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter
// Shares one single-port memory bus between the CPU (port 0) and a DMA/debug
// loader (port 1). The CPU has fixed priority. Port 1 gets a forced grant once
// it has been denied MAX_WAIT cycles in a row. A granted port that asserts
// lock keeps the bus for the following cycle so read-modify-write sequences
// stay atomic. The lock outranks the starvation guard.
// Arbitration is combinational: the access reaches memory in the same cycle
// as its grant. Read data comes back one cycle later and is flagged to the
// port that issued the read.
module mem_bus_arbiter #(
    parameter int ADDR_W   = 16,
    parameter int DATA_W   = 8,
    parameter int MAX_WAIT = 4,
    parameter int WAIT_W   = 3
) (
    input  logic              clk,
    input  logic              resetn,

    // port 0: CPU core
    input  logic              p0_req,
    input  logic              p0_lock,
    input  logic              p0_we,
    input  logic [ADDR_W-1:0] p0_addr,
    input  logic [DATA_W-1:0] p0_wdata,
    output logic              p0_gnt,
    output logic              p0_rvalid,

    // port 1: DMA / debug loader
    input  logic              p1_req,
    input  logic              p1_lock,
    input  logic              p1_we,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic [DATA_W-1:0] p1_wdata,
    output logic              p1_gnt,
    output logic              p1_rvalid,

    // shared read data
    output logic [DATA_W-1:0] rdata,

    // memory side
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    // Port that held the bus in the previous cycle. Encoding 2'b11 is never
    // assigned, and it matches neither lock test, so it acts as NONE.
    typedef enum logic [1:0] {
        OWN_NONE = 2'b00,
        OWN_P0   = 2'b01,
        OWN_P1   = 2'b10
    } owner_t;

    localparam logic [WAIT_W-1:0] MAX_WAIT_C = WAIT_W'(MAX_WAIT);

    owner_t              r_owner;
    logic                r_lock_q;
    logic [WAIT_W-1:0]   r_wait_cnt;
    logic                r_p0_rvalid;
    logic                r_p1_rvalid;

    logic                w_p0_gnt;
    logic                w_p1_gnt;
    logic                w_p0_locked;
    logic                w_p1_locked;
    logic                w_p1_starved;

    // A lock only holds the bus while its owner keeps requesting.
    // If the owner drops req, the lock is void and normal priority applies.
    assign w_p0_locked  = (r_owner == OWN_P0) && r_lock_q && p0_req;
    assign w_p1_locked  = (r_owner == OWN_P1) && r_lock_q && p1_req;
    assign w_p1_starved = p1_req && (r_wait_cnt == MAX_WAIT_C);

    // Grant decision, in priority order: lock, starvation guard, port 0, port 1.
    // Grants are suppressed while reset is held.
    always_comb begin
        // NOTE: every signal gets a default before the if-chain; a path that
        // leaves a combinational output unassigned would infer a latch.
        w_p0_gnt = 1'b0;
        w_p1_gnt = 1'b0;
        if (resetn) begin
            if (w_p0_locked) begin
                w_p0_gnt = 1'b1;
            end else if (w_p1_locked) begin
                w_p1_gnt = 1'b1;
            end else if (w_p1_starved) begin
                w_p1_gnt = 1'b1;
            end else if (p0_req) begin
                w_p0_gnt = 1'b1;
            end else if (p1_req) begin
                w_p1_gnt = 1'b1;
            end
        end
    end

    // Memory mux. With no grant, the bus shows port 0's address and data
    // with the write enable held low.
    always_comb begin
        mem_addr  = p0_addr;
        mem_wdata = p0_wdata;
        mem_we    = 1'b0;
        if (w_p1_gnt) begin
            mem_addr  = p1_addr;
            mem_wdata = p1_wdata;
            mem_we    = p1_we;
        end else if (w_p0_gnt) begin
            mem_we    = p0_we;
        end
    end

    // Arbitration state: owner, its sampled lock, the port-1 wait counter,
    // and the per-port read-valid flags.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments, so every
        // register samples the pre-edge values regardless of statement order.
        if (!resetn) begin
            r_owner     <= OWN_NONE;
            r_lock_q    <= 1'b0;
            r_wait_cnt  <= '0;
            r_p0_rvalid <= 1'b0;
            r_p1_rvalid <= 1'b0;
        end else begin
            if (w_p0_gnt) begin
                r_owner <= OWN_P0;
            end else if (w_p1_gnt) begin
                r_owner <= OWN_P1;
            end else begin
                r_owner <= OWN_NONE;
            end

            r_lock_q <= (w_p0_gnt & p0_lock) | (w_p1_gnt & p1_lock);

            // Count consecutive denied port-1 cycles, saturating at MAX_WAIT.
            if (w_p1_gnt || !p1_req) begin
                r_wait_cnt <= '0;
            end else if (r_wait_cnt != MAX_WAIT_C) begin
                r_wait_cnt <= r_wait_cnt + 1'b1;
            end

            // Memory read latency is one cycle. Flag the port that issued the read.
            r_p0_rvalid <= w_p0_gnt & ~p0_we;
            r_p1_rvalid <= w_p1_gnt & ~p1_we;
        end
    end

    assign p0_gnt    = w_p0_gnt;
    assign p1_gnt    = w_p1_gnt;
    assign p0_rvalid = r_p0_rvalid;
    assign p1_rvalid = r_p1_rvalid;
    assign rdata     = mem_rdata;

    // Grants are exclusive, and memory is never written without a grant.
    a_gnt_onehot : assert property (@(posedge clk) !(w_p0_gnt && w_p1_gnt));
    a_we_needs_gnt : assert property (@(posedge clk) mem_we |-> (w_p0_gnt || w_p1_gnt));

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed, table-driven bench for mem_bus_arbiter. Each table record holds
// one cycle of inputs plus hand-derived grant and rvalid expectations. The
// expected memory-bus values follow from the expected grant. A hand-written
// sequence covers reset asserted in the middle of a read.
module tb_mem_bus_arbiter;

    logic        clk = 1'b0;
    logic        resetn;
    logic        p0_req, p0_lock, p0_we;
    logic [15:0] p0_addr;
    logic [7:0]  p0_wdata;
    logic        p0_gnt, p0_rvalid;
    logic        p1_req, p1_lock, p1_we;
    logic [15:0] p1_addr;
    logic [7:0]  p1_wdata;
    logic        p1_gnt, p1_rvalid;
    logic [7:0]  rdata;
    logic [15:0] mem_addr;
    logic        mem_we;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mem_bus_arbiter #(.ADDR_W(16), .DATA_W(8), .MAX_WAIT(4), .WAIT_W(3)) dut (
        .clk       (clk),
        .resetn    (resetn),
        .p0_req    (p0_req),
        .p0_lock   (p0_lock),
        .p0_we     (p0_we),
        .p0_addr   (p0_addr),
        .p0_wdata  (p0_wdata),
        .p0_gnt    (p0_gnt),
        .p0_rvalid (p0_rvalid),
        .p1_req    (p1_req),
        .p1_lock   (p1_lock),
        .p1_we     (p1_we),
        .p1_addr   (p1_addr),
        .p1_wdata  (p1_wdata),
        .p1_gnt    (p1_gnt),
        .p1_rvalid (p1_rvalid),
        .rdata     (rdata),
        .mem_addr  (mem_addr),
        .mem_we    (mem_we),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    typedef struct {
        string       name;
        logic        rst_n;
        logic        r0, l0, we0;
        logic [15:0] a0;
        logic [7:0]  d0;
        logic        r1, l1, we1;
        logic [15:0] a1;
        logic [7:0]  d1;
        logic [7:0]  mrd;
        logic        eg0, eg1, erv0, erv1;
    } vec_t;

    vec_t vecs[$];

    logic [15:0] cur_a0 = 16'h1111;
    logic [7:0]  cur_d0 = 8'h11;
    logic [15:0] cur_a1 = 16'h2222;
    logic [7:0]  cur_d1 = 8'h22;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic add(input string name, input logic rst_n,
                       input logic r0, input logic l0, input logic we0,
                       input logic r1, input logic l1, input logic we1,
                       input logic [7:0] mrd,
                       input logic eg0, input logic eg1, input logic erv0, input logic erv1);
        vec_t v;
        v.name = name;  v.rst_n = rst_n;
        v.r0 = r0; v.l0 = l0; v.we0 = we0; v.a0 = cur_a0; v.d0 = cur_d0;
        v.r1 = r1; v.l1 = l1; v.we1 = we1; v.a1 = cur_a1; v.d1 = cur_d1;
        v.mrd = mrd;
        v.eg0 = eg0; v.eg1 = eg1; v.erv0 = erv0; v.erv1 = erv1;
        vecs.push_back(v);
    endtask

    task automatic drive(input vec_t v);
        resetn    = v.rst_n;
        p0_req    = v.r0;  p0_lock = v.l0;  p0_we = v.we0;
        p0_addr   = v.a0;  p0_wdata = v.d0;
        p1_req    = v.r1;  p1_lock = v.l1;  p1_we = v.we1;
        p1_addr   = v.a1;  p1_wdata = v.d1;
        mem_rdata = v.mrd;
    endtask

    task automatic compare(input vec_t v, input int idx);
        logic [15:0] e_addr;
        logic [7:0]  e_wd;
        logic        e_we;
        string       tag;
        e_addr = v.eg1 ? v.a1 : v.a0;
        e_wd   = v.eg1 ? v.d1 : v.d0;
        e_we   = (v.eg0 & v.we0) | (v.eg1 & v.we1);
        tag    = $sformatf("%s[%0d]", v.name, idx);
        check({tag, " gnt"},    {30'd0, p0_gnt, p1_gnt},       {30'd0, v.eg0, v.eg1});
        check({tag, " rvalid"}, {30'd0, p0_rvalid, p1_rvalid}, {30'd0, v.erv0, v.erv1});
        check({tag, " mem"},    {7'd0, mem_addr, mem_we, mem_wdata}, {7'd0, e_addr, e_we, e_wd});
        check({tag, " rdata"},  {24'd0, rdata},                {24'd0, v.mrd});
    endtask

    // Drive one table record shortly after a rising edge, sample at the
    // falling edge, then advance to the next rising edge.
    task automatic run_table();
        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i]);
            @(negedge clk);
            compare(vecs[i], i);
            @(posedge clk);
            #1;
        end
        vecs.delete();
    endtask

    initial begin
        vec_t hv;

        // Power-up reset before any sampling, so registered outputs are known.
        resetn = 1'b0;
        p0_req = 1'b0; p0_lock = 1'b0; p0_we = 1'b0; p0_addr = cur_a0; p0_wdata = cur_d0;
        p1_req = 1'b0; p1_lock = 1'b0; p1_we = 1'b0; p1_addr = cur_a1; p1_wdata = cur_d1;
        mem_rdata = 8'h00;
        repeat (2) @(posedge clk);
        #1;

        // Reset held: both ports request writes, and nothing may reach memory.
        add("rst_hold", 0, 1,0,1, 1,0,1, 8'hC3, 0,0,0,0);

        // Port 0 read of 1234, with data 5A on the next cycle.
        cur_a0 = 16'h1234;
        add("p0_read", 1, 1,0,0, 0,0,0, 8'h00, 1,0,0,0);
        add("p0_read", 1, 0,0,0, 0,0,0, 8'h5A, 0,0,1,0);
        cur_a0 = 16'h1111;

        // Port 1 write of A5 to 0200. A write produces no rvalid.
        cur_a1 = 16'h0200; cur_d1 = 8'hA5;
        add("p1_write", 1, 0,0,0, 1,0,1, 8'h3C, 0,1,0,0);
        cur_a1 = 16'h2222; cur_d1 = 8'h22;
        add("p1_write", 1, 0,0,0, 0,0,0, 8'h3C, 0,0,0,0);

        // Both ports request continuously. Port 1 wins every 5th cycle.
        for (int k = 1; k <= 10; k++) begin
            logic g1;
            g1 = (k == 5) || (k == 10);
            add("starve", 1, 1,0,0, 1,0,0, 8'(k),
                !g1, g1, (k != 1) && (k != 6), (k == 6));
        end
        add("starve", 1, 0,0,0, 0,0,0, 8'h77, 0,0,0,1);

        // Port 1 locked for 3 grants keeps the bus 4 cycles against port 0.
        add("p1_lock", 1, 0,0,0, 1,1,0, 8'h81, 0,1,0,0);
        add("p1_lock", 1, 1,0,0, 1,1,0, 8'h82, 0,1,0,1);
        add("p1_lock", 1, 1,0,0, 1,1,0, 8'h83, 0,1,0,1);
        add("p1_lock", 1, 1,0,0, 1,0,0, 8'h84, 0,1,0,1);
        add("p1_lock", 1, 1,0,0, 1,0,0, 8'h85, 1,0,0,1);
        add("p1_lock", 1, 0,0,0, 0,0,0, 8'h86, 0,0,1,0);

        // Port 0 holds a lock for 8 cycles. The lock beats the starvation guard.
        for (int k = 1; k <= 8; k++) begin
            add("p0_lock", 1, 1,1,1, 1,0,0, 8'h90, 1,0,0,0);
        end
        add("p0_lock", 1, 1,0,1, 1,0,0, 8'h91, 1,0,0,0);  // last locked grant
        add("p0_lock", 1, 1,0,1, 1,0,0, 8'h92, 0,1,0,0);  // starved p1 wins
        add("p0_lock", 1, 1,0,1, 1,0,0, 8'h93, 1,0,0,1);
        add("p0_lock", 1, 1,1,1, 1,0,0, 8'h94, 1,0,0,0);
        // Lock holder drops req, so its lock is void and p1 is granted.
        add("lock_void", 1, 0,1,1, 1,0,0, 8'h95, 0,1,0,0);
        add("lock_void", 1, 0,0,0, 0,0,0, 8'h96, 0,0,0,1);

        // Build up a wait count of 3 before the reset test.
        add("pre_rst", 1, 1,0,0, 1,0,0, 8'hA1, 1,0,0,0);
        add("pre_rst", 1, 1,0,0, 1,0,0, 8'hA2, 1,0,1,0);
        add("pre_rst", 1, 1,0,0, 1,0,0, 8'hA3, 1,0,1,0);
        run_table();

        // Reset asserted in the cycle of a granted port-0 read.
        hv.name = "mid_rst"; hv.rst_n = 1'b1;
        hv.r0 = 1; hv.l0 = 0; hv.we0 = 0; hv.a0 = cur_a0; hv.d0 = cur_d0;
        hv.r1 = 1; hv.l1 = 0; hv.we1 = 0; hv.a1 = cur_a1; hv.d1 = cur_d1;
        hv.mrd = 8'hB0; hv.eg0 = 1; hv.eg1 = 0; hv.erv0 = 1; hv.erv1 = 0;
        drive(hv);
        @(negedge clk);
        compare(hv, 0);
        #1;
        resetn = 1'b0;
        p0_we  = 1'b1;
        #1;
        check("mid_rst gnt_in_reset", {30'd0, p0_gnt, p1_gnt}, 32'd0);
        check("mid_rst we_in_reset",  {31'd0, mem_we},         32'd0);
        @(posedge clk);
        #1;
        check("mid_rst rvalid_dropped", {30'd0, p0_rvalid, p1_rvalid}, 32'd0);

        // After release, the wait count must restart from zero.
        add("post_rst", 0, 1,0,0, 1,0,0, 8'hB1, 0,0,0,0);
        for (int k = 1; k <= 5; k++) begin
            add("post_rst", 1, 1,0,0, 1,0,0, 8'hB2, (k != 5), (k == 5), (k != 1), 0);
        end
        add("post_rst", 1, 0,0,0, 0,0,0, 8'hB3, 0,0,0,1);
        run_table();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
